// File: rtl/arcade_dl_pkg.sv
// rtl/arcade_dl_pkg.sv - shared types and defaults for the arcade download router
package arcade_dl_pkg;

  // Core-reset sequencing states
  typedef enum logic [1:0] {
    BOOT,
    LOAD,
    HOLD,
    RUN
  } dl_state_t;

  localparam logic [7:0] ROM_INDEX_DEFAULT = 8'd0;
  localparam logic [7:0] DIP_INDEX_DEFAULT = 8'd254;
  localparam int         MAX_REGIONS       = 8;

  // Region boundaries, entry k is B[k]; only entries 0..NUM_REGIONS are used
  typedef logic [MAX_REGIONS:0][24:0] bound_arr_t;

  localparam bound_arr_t BOUND_DEFAULT = {
    25'h0, 25'h0, 25'h0, 25'h0,
    25'h20000, 25'h18000, 25'h10000, 25'h08000, 25'h0
  };

endpackage

// File: rtl/arcade_dl_router_decode.sv
// rtl/arcade_dl_router_decode.sv - combinational byte address to ROM region decode
module dl_region_decode
  import arcade_dl_pkg::*;
#(
  parameter int         NUM_REGIONS  = 4,
  parameter int         REGION_AW    = 16,
  parameter int         KW           = 2,
  parameter bound_arr_t REGION_BOUND = BOUND_DEFAULT
) (
  input  logic [24:0]          addr,
  output logic                 hit,
  output logic [KW-1:0]        k,
  output logic [REGION_AW-1:0] offset
);

  logic [NUM_REGIONS-1:0] in_rng;

  // Ascending boundaries make the ranges disjoint, so at most one bit is set
  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_rng
    assign in_rng[g] = (addr >= REGION_BOUND[g]) && (addr < REGION_BOUND[g+1]);
  end

  // Encode the matching region and its region-relative offset
  always_comb begin
    hit    = |in_rng;
    k      = '0;
    offset = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (in_rng[i]) begin
        k      = KW'(i);
        offset = REGION_AW'(addr - REGION_BOUND[i]);
      end
    end
  end

endmodule

// File: rtl/arcade_dl_router.sv
// rtl/arcade_dl_router.sv - routes hps_io downloads to ROM regions and a DIP bank, sequences core reset
module arcade_dl_router
  import arcade_dl_pkg::*;
#(
  parameter int                     NUM_REGIONS  = 4,
  parameter int                     REGION_AW    = 16,
  parameter bound_arr_t             REGION_BOUND = BOUND_DEFAULT,
  parameter int                     DIP_BYTES    = 8,
  parameter logic [DIP_BYTES*8-1:0] DIP_DEFAULT  = '0,
  parameter logic [7:0]             ROM_INDEX    = ROM_INDEX_DEFAULT,
  parameter logic [7:0]             DIP_INDEX    = DIP_INDEX_DEFAULT,
  parameter int                     HOLD_CYCLES  = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     ioctl_download,
  input  logic [7:0]               ioctl_index,
  input  logic                     ioctl_wr,
  input  logic [24:0]              ioctl_addr,
  input  logic [7:0]               ioctl_dout,
  output logic [NUM_REGIONS-1:0]   region_wr,
  output logic [REGION_AW-1:0]     region_addr,
  output logic [7:0]               region_data,
  output logic [DIP_BYTES*8-1:0]   dip_sw,
  output logic                     dip_valid,
  output logic                     rom_loaded,
  output logic                     core_reset,
  output logic                     err_unmapped
);

  localparam int KW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  dl_state_t            state, state_next;
  logic [HW-1:0]        hold_cnt;
  logic                 hold_done;
  logic                 dl_prev, dl_rise, dl_fall;
  logic                 rom_start, dip_start;
  logic                 rom_wr, dip_wr;
  logic                 dip_active;
  logic                 mapped_seen;
  logic                 dec_hit;
  logic [KW-1:0]        dec_k;
  logic [REGION_AW-1:0] dec_offset;

  dl_region_decode #(
    .NUM_REGIONS  (NUM_REGIONS),
    .REGION_AW    (REGION_AW),
    .KW           (KW),
    .REGION_BOUND (REGION_BOUND)
  ) u_decode (
    .addr   (ioctl_addr),
    .hit    (dec_hit),
    .k      (dec_k),
    .offset (dec_offset)
  );

  assign dl_rise   = ioctl_download & ~dl_prev;
  assign dl_fall   = ~ioctl_download & dl_prev;
  assign rom_start = dl_rise & (ioctl_index == ROM_INDEX);
  assign dip_start = dl_rise & (ioctl_index == DIP_INDEX);
  assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
  assign rom_wr    = (state == LOAD) & ioctl_download & ioctl_wr;
  assign dip_wr    = dip_active & ioctl_download & ioctl_wr & (ioctl_index == DIP_INDEX)
                   & (ioctl_addr < 25'(DIP_BYTES));
  assign core_reset = (state != RUN);

  // Download level history; resets high so a download already in progress at release is not a rise
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) dl_prev <= 1'b1;
    else          dl_prev <= ioctl_download;
  end

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= BOOT;
    else          state <= state_next;
  end

  // Next-state: a ROM download start wins from any state
  always_comb begin
    state_next = state;
    if (rom_start) begin
      state_next = LOAD;
    end else begin
      case (state)
        BOOT:    if (hold_done) state_next = RUN;
        LOAD:    if (dl_fall)   state_next = HOLD;
        HOLD:    if (hold_done) state_next = RUN;
        default: state_next = state;
      endcase
    end
  end

  // Reset-extension counter: cleared by LOAD, counts through BOOT and HOLD
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
    end else if (rom_start || state == LOAD) begin
      hold_cnt <= '0;
    end else if (state == BOOT || state == HOLD) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  // ROM write strobes, region address/data, and load status flags
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      region_wr    <= '0;
      region_addr  <= '0;
      region_data  <= '0;
      rom_loaded   <= 1'b0;
      err_unmapped <= 1'b0;
      mapped_seen  <= 1'b0;
    end else begin
      region_wr <= '0;
      if (rom_start) begin
        rom_loaded   <= 1'b0;
        err_unmapped <= 1'b0;
        mapped_seen  <= 1'b0;
      end else if (rom_wr) begin
        if (dec_hit) begin
          region_wr   <= NUM_REGIONS'(1) << dec_k;
          region_addr <= dec_offset;
          region_data <= ioctl_dout;
          mapped_seen <= 1'b1;
        end else begin
          err_unmapped <= 1'b1;
        end
      end else if (state == LOAD && dl_fall) begin
        rom_loaded <= mapped_seen;
      end
    end
  end

  // DIP bank capture; independent of the reset sequencing
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dip_sw     <= DIP_DEFAULT;
      dip_valid  <= 1'b0;
      dip_active <= 1'b0;
    end else begin
      if (dip_start) begin
        dip_active <= 1'b1;
      end else if (dl_fall) begin
        dip_active <= 1'b0;
        if (dip_active) dip_valid <= 1'b1;
      end
      for (int i = 0; i < DIP_BYTES; i++) begin
        if (dip_wr && ioctl_addr == 25'(i)) dip_sw[8*i +: 8] <= ioctl_dout;
      end
    end
  end

endmodule

// File: tb/tb_arcade_dl_router.sv
// tb/tb_arcade_dl_router.sv - self-checking bench for arcade_dl_router
module tb_arcade_dl_router;
  import arcade_dl_pkg::*;

  localparam bound_arr_t BND = {25'h0, 25'h0, 25'h0, 25'h0, 25'h0,
                                25'hE000, 25'hC000, 25'h8000, 25'h0};
  localparam logic [63:0] DEF = 64'h0123_4567_89AB_CDEF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic [2:0]  region_wr;
  logic [15:0] region_addr;
  logic [7:0]  region_data;
  logic [63:0] dip_sw;
  logic        dip_valid, rom_loaded, core_reset, err_unmapped;

  arcade_dl_router #(
    .NUM_REGIONS(3), .REGION_AW(16), .REGION_BOUND(BND), .DIP_BYTES(8),
    .DIP_DEFAULT(DEF), .ROM_INDEX(8'd0), .DIP_INDEX(8'd254), .HOLD_CYCLES(16)
  ) dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .region_wr(region_wr), .region_addr(region_addr),
    .region_data(region_data), .dip_sw(dip_sw), .dip_valid(dip_valid),
    .rom_loaded(rom_loaded), .core_reset(core_reset), .err_unmapped(err_unmapped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [2:0]  wr;
    logic [15:0] off;
  } vec_t;

  vec_t       tbl[8];
  int         n_checks = 0;
  int         n_errors = 0;
  bit         m_err;
  logic [7:0] m_dip[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // Region k is the number of interior boundaries at or below the address
  function automatic void ref_decode(input int unsigned a, output bit hit, output int k,
                                     output int unsigned off);
    int unsigned b[4] = '{32'h0, 32'h8000, 32'hC000, 32'hE000};
    hit = (a >= b[0]) && (a < b[3]);
    k = 0;
    for (int j = 1; j < 3; j++) if (a >= b[j]) k++;
    off = (a - b[k]) & 32'hFFFF;
  endfunction

  function automatic logic [63:0] dip_pack();
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = m_dip[i];
    return r;
  endfunction

  task automatic hold_check(input string name);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk(name, core_reset, (i < 16) ? 1 : 0);
    end
  endtask

  initial begin
    bit          hit;
    int          k;
    int unsigned off, a;
    logic [7:0]  d;

    tbl[0] = '{25'h7FFF,    8'hA5, 3'b001, 16'h7FFF};
    tbl[1] = '{25'h8000,    8'h3C, 3'b010, 16'h0000};
    tbl[2] = '{25'hDFFF,    8'h5A, 3'b100, 16'h1FFF};
    tbl[3] = '{25'h0000,    8'h11, 3'b001, 16'h0000};
    tbl[4] = '{25'hBFFF,    8'h22, 3'b010, 16'h3FFF};
    tbl[5] = '{25'hC000,    8'h33, 3'b100, 16'h0000};
    tbl[6] = '{25'hE000,    8'h44, 3'b000, 16'h0000};
    tbl[7] = '{25'h1FFFFFF, 8'h55, 3'b000, 16'h0000};

    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    for (int i = 0; i < 8; i++) m_dip[i] = DEF[8*i +: 8];

    // Reset values
    repeat (3) tick();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_dip_sw", dip_sw, DEF);
    chk("rst_region_wr", region_wr, 0);
    chk("rst_dip_valid", dip_valid, 0);
    chk("rst_rom_loaded", rom_loaded, 0);
    chk("rst_err", err_unmapped, 0);

    // Boot: core reset held 16 cycles with no download
    reset_n = 1'b1;
    hold_check("boot_core_reset");
    chk("boot_dip_sw", dip_sw, DEF);

    // ROM download: boundary table
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    chk("load_core_reset", core_reset, 1);
    m_err = 0;
    for (int i = 0; i < 8; i++) begin
      wr_byte(tbl[i].addr, tbl[i].data);
      if (tbl[i].wr == 3'b000) m_err = 1;
      chk("tbl_region_wr", region_wr, tbl[i].wr);
      if (tbl[i].wr != 3'b000) begin
        chk("tbl_region_addr", region_addr, tbl[i].off);
        chk("tbl_region_data", region_data, tbl[i].data);
      end
      chk("tbl_err", err_unmapped, m_err);
      tick();
      chk("tbl_strobe_len", region_wr, 0);
    end

    // ROM download: random addresses against the reference decode
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom_range(32'hE000, 32'h1FFFFFF)
                                      : $urandom_range(0, 32'hDFFF);
      d = 8'($urandom);
      wr_byte(25'(a), d);
      ref_decode(a, hit, k, off);
      if (hit) begin
        chk("rnd_region_wr", region_wr, 3'b001 << k);
        chk("rnd_region_addr", region_addr, off);
        chk("rnd_region_data", region_data, d);
      end else begin
        m_err = 1;
        chk("rnd_region_wr_none", region_wr, 0);
      end
      chk("rnd_err", err_unmapped, m_err);
    end

    // Download end: hold then run
    ioctl_download = 1'b0;
    tick();
    chk("end_rom_loaded", rom_loaded, 1);
    chk("end_err", err_unmapped, 1);
    hold_check("hold1_core_reset");

    // DIP download in RUN
    ioctl_index = 8'd254;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'd1, 8'hC2);
    m_dip[1] = 8'hC2;
    chk("dip_byte1", dip_sw[15:8], 8'hC2);
    chk("dip_bank_a", dip_sw, dip_pack());
    wr_byte(25'd9, 8'h77);
    chk("dip_addr9_ignored", dip_sw, dip_pack());
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 11);
      d = 8'($urandom);
      wr_byte(25'(a), d);
      if (a < 8) m_dip[a] = d;
      chk("dip_rnd", dip_sw, dip_pack());
    end
    chk("dip_valid_before", dip_valid, 0);
    chk("dip_core_reset", core_reset, 0);
    ioctl_download = 1'b0;
    tick();
    tick();
    chk("dip_valid_after", dip_valid, 1);
    chk("dip_core_reset_after", core_reset, 0);

    // Second ROM download restarted during HOLD
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h100, 8'h01);
    chk("r2_region_wr", region_wr, 3'b001);
    wr_byte(25'hE000, 8'h02);
    chk("r2_err", err_unmapped, 1);
    ioctl_download = 1'b0;
    tick();
    chk("r2_rom_loaded", rom_loaded, 1);
    repeat (4) tick();
    ioctl_download = 1'b1;
    tick();
    chk("r3_err_cleared", err_unmapped, 0);
    chk("r3_rom_loaded_cleared", rom_loaded, 0);
    chk("r3_core_reset", core_reset, 1);
    tick();
    ioctl_download = 1'b0;
    tick();
    chk("r3_rom_loaded_empty", rom_loaded, 0);
    hold_check("hold2_core_reset");
    chk("r3_dip_valid_kept", dip_valid, 1);

    // Asynchronous reset mid-LOAD
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h10, 8'h99);
    chk("r4_region_wr", region_wr, 3'b001);
    reset_n = 1'b0;
    #1;
    chk("ar_region_wr", region_wr, 0);
    chk("ar_region_addr", region_addr, 0);
    chk("ar_region_data", region_data, 0);
    chk("ar_dip_sw", dip_sw, DEF);
    chk("ar_dip_valid", dip_valid, 0);
    chk("ar_rom_loaded", rom_loaded, 0);
    chk("ar_core_reset", core_reset, 1);
    tick();
    reset_n = 1'b1;
    wr_byte(25'hE000, 8'h12);
    chk("ar_ignored_err", err_unmapped, 0);
    chk("ar_ignored_wr_a", region_wr, 0);
    wr_byte(25'h20, 8'h34);
    chk("ar_ignored_wr_b", region_wr, 0);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    wr_byte(25'h20, 8'h66);
    chk("ar_new_wr", region_wr, 3'b001);
    chk("ar_new_addr", region_addr, 16'h20);
    chk("ar_new_data", region_data, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
